uart_rxd: RTL and testbench
===========================

UART_RXD -- requirements
Module: uart_rxd

Interface
REQ-001 The block SHALL have parameter CLKS_PER_BIT, default 16'h0190, giving clk cycles per serial bit (9600 bps); legal range 4..65535.
REQ-002 The block SHALL have port clk  input  1  system clock; all state changes on its rising edge.
REQ-003 The block SHALL have port rst_n  input  1  reset, asynchronous, active-low.
REQ-004 The block SHALL have port rxd  input  1  asynchronous serial line; idles high.
REQ-005 The block SHALL have port parity_en  input  1  1 = a parity bit follows the 8 data bits.
REQ-006 The block SHALL have port parity_kind  input  1  1 = odd parity, 0 = even parity.
REQ-007 The block SHALL have port rd_ack  input  1  single-cycle pulse; consumer has read rx_data.
REQ-008 The block SHALL have port rx_data  output  8  last accepted byte.
REQ-009 The block SHALL have port rx_ready  output  1  rx_data holds an unread byte.
REQ-010 The block SHALL have port parity_err  output  1  parity mismatch on the byte in rx_data.
REQ-011 The block SHALL have port frame_err  output  1  stop bit sampled low on the byte in rx_data.
REQ-012 The block SHALL have port overrun  output  1  a frame completed while rx_ready was 1.
REQ-013 The block SHALL have port busy  output  1  high in every state except IDLE.

Function
REQ-014 rxd SHALL pass through a 2-flop synchronizer; all decisions use the synchronized value rxs.
REQ-015 FSM states SHALL be IDLE, START, DATA, PARITY, STOP; one bit counter (16 bit) and one 3-bit data index.
REQ-016 IDLE -> START on rxs 1->0 transition; bit counter cleared.
REQ-017 START: at count CLKS_PER_BIT/2 - 1 (integer division), sample rxs; 0 -> DATA with counter cleared, 1 -> IDLE (false start, no flags change).
REQ-018 DATA: sample rxs every CLKS_PER_BIT cycles (mid-bit), LSB first into shift register; after 8th sample -> PARITY if parity_en else STOP.
REQ-019 PARITY: sample one bit; mismatch when XOR(8 data bits, parity bit) != parity_kind; -> STOP.
REQ-020 STOP: sample one bit; then complete the frame in that same cycle and return to IDLE (no wait for full stop-bit time; back-to-back frames accepted).
REQ-021 Completion with rx_ready=0: rx_data <= shift register, parity_err <= mismatch (0 if parity_en=0), frame_err <= (stop sample==0), rx_ready <= 1.
REQ-022 Completion with rx_ready=1 and no rd_ack that cycle: new byte discarded, rx_data/parity_err/frame_err unchanged, overrun <= 1.
REQ-023 Completion and rd_ack in same cycle: treated as REQ-021; overrun not set.
REQ-024 rd_ack with no completion: rx_ready <= 0 and overrun <= 0 next edge; rx_data, parity_err, frame_err hold until next completion.
REQ-025 rd_ack while rx_ready=0 SHALL have no effect.
REQ-026 parity_en and parity_kind SHALL be sampled when leaving DATA; changes mid-frame do not affect the current frame.
REQ-027 Error frames SHALL never lock the FSM; receiver always returns to IDLE after STOP.

Reset
REQ-028 rst_n low SHALL immediately force: state IDLE, counters 0, synchronizer flops 1, rx_data 8'h00, rx_ready 0, parity_err 0, frame_err 0, overrun 0, busy 0.
REQ-029 Reset asserted mid-frame SHALL abort the frame with no output update; after release, the next 1->0 edge on rxs starts a fresh frame.

Verification (CLKS_PER_BIT=16)
REQ-030 Send 0xA5, parity off, stop=1 -> rx_ready=1, rx_data=8'hA5, parity_err=0, frame_err=0; rd_ack -> rx_ready=0.
REQ-031 Send 0x03 with odd parity (parity bit 1), then with parity bit 0 -> first parity_err=0, second parity_err=1, rx_data=8'h03 both.
REQ-032 rxd low for 6 clk then high -> busy rises then returns to IDLE, rx_ready stays 0.
REQ-033 Send 0x55 with stop bit 0 -> rx_data=8'h55, frame_err=1; following frame 0x0F with good stop decoded correctly.
REQ-034 Send 0x11, no ack, send 0x22 -> rx_data=8'h11, overrun=1; rd_ack in the 0x22 completion cycle instead -> rx_data=8'h22, overrun=0.
REQ-035 Pulse rst_n low during DATA bit 4 -> all outputs at reset values; next 0x3C frame received correctly.

Source files
------------

// File: rtl/uart_rxd.sv
// uart_rxd -- 8-bit asynchronous serial receiver with optional parity.
//
// Ports
//   clk          system clock, rising edge
//   rst_n        asynchronous active-low reset
//   rxd          serial line, idles high (asynchronous to clk)
//   parity_en    1 = a parity bit follows the 8 data bits
//   parity_kind  1 = odd parity, 0 = even parity
//   rd_ack       single-cycle pulse: consumer has read rx_data
//   rx_data      last accepted byte
//   rx_ready     rx_data holds an unread byte
//   parity_err   parity mismatch on the byte in rx_data
//   frame_err    stop bit sampled low on the byte in rx_data
//   overrun      a frame completed while rx_ready was still set
//   busy         receiver is inside a frame (any state but IDLE)
//
// state  | meaning
// -------+-----------------------------------------------------------
// IDLE   | waiting for a falling edge on the synchronized line
// START  | waiting half a bit to confirm the start bit at mid-bit
// DATA   | sampling 8 data bits, LSB first, one per bit period
// PARITY | sampling the parity bit
// STOP   | sampling the stop bit; frame completes on that sample

module uart_rxd #(
    parameter int unsigned CLKS_PER_BIT = 16'h0190
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       rxd,
    input  logic       parity_en,
    input  logic       parity_kind,
    input  logic       rd_ack,
    output logic [7:0] rx_data,
    output logic       rx_ready,
    output logic       parity_err,
    output logic       frame_err,
    output logic       overrun,
    output logic       busy
);

    localparam logic [15:0] FULL_TC = 16'(CLKS_PER_BIT - 1);
    localparam logic [15:0] HALF_TC = 16'(CLKS_PER_BIT / 2 - 1);

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        START  = 3'd1,
        DATA   = 3'd2,
        PARITY = 3'd3,
        STOP   = 3'd4
    } state_t;

    state_t      state, state_nxt;
    logic        sync1, rxs, rxs_d;
    logic [15:0] bit_cnt;
    logic [2:0]  bit_idx;
    logic [7:0]  shift_reg;
    logic        par_en_q, par_kind_q, par_bit;

    logic        cnt_clr;
    logic        enter_data;
    logic        shift_en;
    logic        leave_data;
    logic        par_sample;
    logic        complete;
    logic        mismatch;

    // Two-flop synchronizer; rxs_d keeps the previous synchronized value
    // for start-edge detection. All flops reset to the idle (high) level
    // so reset release never looks like a start edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1 <= 1'b1;
            rxs   <= 1'b1;
            rxs_d <= 1'b1;
        end else begin
            sync1 <= rxd;
            rxs   <= sync1;
            rxs_d <= rxs;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt  = state;
        cnt_clr    = 1'b0;
        enter_data = 1'b0;
        shift_en   = 1'b0;
        leave_data = 1'b0;
        par_sample = 1'b0;
        complete   = 1'b0;
        case (state)
            IDLE: begin
                if (rxs_d && !rxs) begin
                    state_nxt = START;
                    cnt_clr   = 1'b1;
                end
            end
            START: begin
                if (bit_cnt == HALF_TC) begin
                    cnt_clr = 1'b1;
                    if (rxs) begin
                        state_nxt = IDLE;
                    end else begin
                        state_nxt  = DATA;
                        enter_data = 1'b1;
                    end
                end
            end
            DATA: begin
                if (bit_cnt == FULL_TC) begin
                    cnt_clr  = 1'b1;
                    shift_en = 1'b1;
                    if (bit_idx == 3'd7) begin
                        leave_data = 1'b1;
                        state_nxt  = parity_en ? PARITY : STOP;
                    end
                end
            end
            PARITY: begin
                if (bit_cnt == FULL_TC) begin
                    cnt_clr    = 1'b1;
                    par_sample = 1'b1;
                    state_nxt  = STOP;
                end
            end
            STOP: begin
                if (bit_cnt == FULL_TC) begin
                    cnt_clr   = 1'b1;
                    complete  = 1'b1;
                    state_nxt = IDLE;
                end
            end
            default: begin
                state_nxt = IDLE;
                cnt_clr   = 1'b1;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bit_cnt    <= 16'd0;
            bit_idx    <= 3'd0;
            shift_reg  <= 8'h00;
            par_en_q   <= 1'b0;
            par_kind_q <= 1'b0;
            par_bit    <= 1'b0;
        end else begin
            if (cnt_clr)
                bit_cnt <= 16'd0;
            else if (state != IDLE)
                bit_cnt <= bit_cnt + 16'd1;

            if (enter_data)
                bit_idx <= 3'd0;
            else if (shift_en)
                bit_idx <= bit_idx + 3'd1;

            if (shift_en)
                shift_reg <= {rxs, shift_reg[7:1]};

            // Parity config is frozen as the frame leaves DATA.
            if (leave_data) begin
                par_en_q   <= parity_en;
                par_kind_q <= parity_kind;
            end

            if (par_sample)
                par_bit <= rxs;
        end
    end

    // Parity bit is cleared on leave_data-less frames? No: par_bit is only
    // meaningful when par_en_q is set, so the mismatch is gated by it.
    assign mismatch = par_en_q && ((^shift_reg ^ par_bit) != par_kind_q);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rx_data    <= 8'h00;
            rx_ready   <= 1'b0;
            parity_err <= 1'b0;
            frame_err  <= 1'b0;
            overrun    <= 1'b0;
        end else if (complete) begin
            if (!rx_ready || rd_ack) begin
                rx_data    <= shift_reg;
                parity_err <= mismatch;
                frame_err  <= !rxs;
                rx_ready   <= 1'b1;
                overrun    <= 1'b0;
            end else begin
                overrun <= 1'b1;
            end
        end else if (rd_ack && rx_ready) begin
            rx_ready <= 1'b0;
            overrun  <= 1'b0;
        end
    end

    assign busy = (state != IDLE);

endmodule

// File: tb/tb_uart_rxd.sv
// tb_uart_rxd -- scoreboard bench for uart_rxd at 16 clocks per bit.
// Stimulus pushes the expected byte/flags when a frame should be accepted;
// a negedge monitor pops and compares whenever a new byte appears.

module tb_uart_rxd;

    localparam int CPB = 16;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       rxd;
    logic       parity_en;
    logic       parity_kind;
    logic       rd_ack;
    logic [7:0] rx_data;
    logic       rx_ready;
    logic       parity_err;
    logic       frame_err;
    logic       overrun;
    logic       busy;

    typedef struct {
        logic [7:0] d;
        logic       pe;
        logic       fe;
    } exp_t;

    exp_t exp_q[$];
    int   compared   = 0;
    int   mismatched = 0;
    logic prev_ready = 1'b0;
    logic prev_ack   = 1'b0;

    uart_rxd #(.CLKS_PER_BIT(CPB)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .rxd        (rxd),
        .parity_en  (parity_en),
        .parity_kind(parity_kind),
        .rd_ack     (rd_ack),
        .rx_data    (rx_data),
        .rx_ready   (rx_ready),
        .parity_err (parity_err),
        .frame_err  (frame_err),
        .overrun    (overrun),
        .busy       (busy)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input int act, input int exp);
        compared++;
        if (act != exp) begin
            mismatched++;
            $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // A new byte is presented when rx_ready rises, or when it stays high
    // across a cycle in which rd_ack was asserted (completion + ack together).
    always @(negedge clk) begin
        exp_t e;
        if (!rst_n) begin
            prev_ready = 1'b0;
            prev_ack   = 1'b0;
        end else begin
            if (rx_ready && (!prev_ready || prev_ack)) begin
                if (exp_q.size() == 0) begin
                    check("unexpected_byte", int'(rx_data), 256);
                end else begin
                    e = exp_q.pop_front();
                    check("rx_data", int'(rx_data), int'(e.d));
                    check("parity_err", int'(parity_err), int'(e.pe));
                    check("frame_err", int'(frame_err), int'(e.fe));
                end
            end
            prev_ready = rx_ready;
            prev_ack   = rd_ack;
        end
    end

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic expect_byte(input logic [7:0] d, input logic pe, input logic fe);
        exp_t e;
        e.d  = d;
        e.pe = pe;
        e.fe = fe;
        exp_q.push_back(e);
    endtask

    // One frame plus one idle bit. ack_at_stop pulses rd_ack exactly in the
    // cycle whose edge takes the stop sample (11 clocks into the stop bit:
    // 3 clocks of sync/edge detect + 8 of half-bit, phase carried forward).
    task automatic send(input logic [7:0] d, input bit par, input bit pbit,
                        input bit stop, input bit ack_at_stop, input bit flip_kind);
        rxd = 1'b0;
        tick(CPB);
        for (int i = 0; i < 8; i++) begin
            rxd = d[i];
            tick(CPB);
        end
        if (par) begin
            rxd = pbit;
            tick(CPB);
        end
        rxd = stop;
        if (flip_kind) parity_kind = ~parity_kind;
        if (ack_at_stop) begin
            tick(10);
            rd_ack = 1'b1;
            tick(1);
            rd_ack = 1'b0;
            tick(CPB - 11);
        end else begin
            tick(CPB);
        end
        rxd = 1'b1;
        tick(CPB);
    endtask

    task automatic ack();
        rd_ack = 1'b1;
        tick(1);
        rd_ack = 1'b0;
        tick(1);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [7:0] b;
        rst_n       = 1'b0;
        rxd         = 1'b1;
        parity_en   = 1'b0;
        parity_kind = 1'b0;
        rd_ack      = 1'b0;
        #23;
        check("rst_rx_data", int'(rx_data), 0);
        check("rst_rx_ready", int'(rx_ready), 0);
        check("rst_parity_err", int'(parity_err), 0);
        check("rst_frame_err", int'(frame_err), 0);
        check("rst_overrun", int'(overrun), 0);
        check("rst_busy", int'(busy), 0);
        tick(1);
        rst_n = 1'b1;
        tick(5);

        // Plain byte, no parity.
        expect_byte(8'hA5, 1'b0, 1'b0);
        send(8'hA5, 0, 0, 1, 0, 0);
        check("a5_ready", int'(rx_ready), 1);
        ack();
        check("a5_ready_after_ack", int'(rx_ready), 0);

        // Odd parity good; parity_kind flipped after DATA must not matter.
        parity_en   = 1'b1;
        parity_kind = 1'b1;
        expect_byte(8'h03, 1'b0, 1'b0);
        send(8'h03, 1, 1, 1, 0, 1);
        ack();
        parity_kind = 1'b1;
        expect_byte(8'h03, 1'b1, 1'b0);
        send(8'h03, 1, 0, 1, 0, 0);
        ack();
        // Even parity: 0x07 has three ones, parity bit 1 makes it even.
        parity_kind = 1'b0;
        expect_byte(8'h07, 1'b0, 1'b0);
        send(8'h07, 1, 1, 1, 0, 0);
        ack();
        parity_en = 1'b0;

        // False start: 6 clocks low.
        rxd = 1'b0;
        tick(6);
        rxd = 1'b1;
        check("false_start_busy_hi", int'(busy), 1);
        tick(20);
        check("false_start_busy_lo", int'(busy), 0);
        check("false_start_ready", int'(rx_ready), 0);

        // Framing error, then a clean frame.
        expect_byte(8'h55, 1'b0, 1'b1);
        send(8'h55, 0, 0, 0, 0, 0);
        ack();
        expect_byte(8'h0F, 1'b0, 1'b0);
        send(8'h0F, 0, 0, 1, 0, 0);
        ack();

        // Overrun: second byte discarded.
        expect_byte(8'h11, 1'b0, 1'b0);
        send(8'h11, 0, 0, 1, 0, 0);
        send(8'h22, 0, 0, 1, 0, 0);
        check("ovr_rx_data", int'(rx_data), 8'h11);
        check("ovr_flag", int'(overrun), 1);
        check("ovr_ready", int'(rx_ready), 1);
        ack();
        check("ovr_cleared", int'(overrun), 0);
        check("ovr_ready_cleared", int'(rx_ready), 0);
        ack();
        check("idle_ack_ready", int'(rx_ready), 0);
        check("idle_ack_rx_data", int'(rx_data), 8'h11);

        // Ack in the completion cycle: new byte taken, no overrun.
        expect_byte(8'h11, 1'b0, 1'b0);
        send(8'h11, 0, 0, 1, 0, 0);
        expect_byte(8'h22, 1'b0, 1'b0);
        send(8'h22, 0, 0, 1, 1, 0);
        check("ack_cmpl_rx_data", int'(rx_data), 8'h22);
        check("ack_cmpl_overrun", int'(overrun), 0);
        check("ack_cmpl_ready", int'(rx_ready), 1);
        ack();

        // Reset in the middle of data bit 4.
        b = 8'h3C;
        rxd = 1'b0;
        tick(CPB);
        for (int i = 0; i < 4; i++) begin
            rxd = b[i];
            tick(CPB);
        end
        rxd = b[4];
        tick(CPB / 2);
        check("mid_frame_busy", int'(busy), 1);
        rst_n = 1'b0;
        #2;
        check("mid_rst_rx_data", int'(rx_data), 0);
        check("mid_rst_ready", int'(rx_ready), 0);
        check("mid_rst_overrun", int'(overrun), 0);
        check("mid_rst_busy", int'(busy), 0);
        rxd = 1'b1;
        tick(3);
        rst_n = 1'b1;
        tick(2 * CPB);
        check("post_rst_busy", int'(busy), 0);
        check("post_rst_ready", int'(rx_ready), 0);
        expect_byte(8'h3C, 1'b0, 1'b0);
        send(8'h3C, 0, 0, 1, 0, 0);
        ack();

        tick(5);
        check("scoreboard_empty", exp_q.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
